stopwatch_lap_core: RTL and testbench
=====================================

// Module: stopwatch_lap_core
// PURPOSE
//   Parametrised timekeeping core for the next-generation stopwatch. Supports up-count and
//   countdown modes, a configurable minute range and a lap-capture FIFO with a show-ahead
//   read port. Sits between the button debouncers and the 7-segment display controller.
//   The 1 ms pulse from clock_divider is its only timebase.
// PARAMETERS
//   TICKS_PER_CS  10  tick_1ms pulses per centisecond
//   MAX_MINUTES   59  highest minute value; must be < 2**MIN_W
//   MIN_W         6   minutes field width
//   LAP_DEPTH     8   lap FIFO entries; power of two, >= 2
//   LAP_AW        3   log2(LAP_DEPTH)
// PORTS
//   clk           in   1          system clock (100 MHz)
//   rst_n         in   1          asynchronous reset, active-low
//   tick_1ms      in   1          1-cycle pulse every 1 ms
//   start_edge    in   1          start/stop toggle pulse
//   reset_edge    in   1          clear/preload pulse
//   lap_edge      in   1          lap capture pulse
//   mode_down     in   1          1 = countdown, 0 = up-count; sampled only in IDLE
//   preset_min    in   MIN_W      countdown preset, minutes
//   preset_sec    in   6          countdown preset, seconds (0..59)
//   running       out  1          1 while state == RUN
//   done          out  1          countdown reached 00:00.00
//   minutes       out  MIN_W      current minutes
//   seconds       out  6          current seconds
//   centiseconds  out  7          current centiseconds
//   lap_rd_en     in   1          pop FIFO head; ignored when lap_empty
//   lap_rd_data   out  MIN_W+13   FIFO head {min,sec,cs}; valid when !lap_empty
//   lap_count     out  LAP_AW+1   entries held
//   lap_empty     out  1          FIFO empty
//   lap_full      out  1          FIFO full
//   lap_overflow  out  1          sticky: a lap was lost or overwritten
// BEHAVIOUR
//   Reset: state IDLE; all time fields, prescaler and lap_count = 0. running, done,
//     lap_full and lap_overflow = 0; lap_empty = 1.
//   FSM IDLE/RUN/PAUSE/DONE, all outputs registered.
//     IDLE  -start-> RUN.  RUN -start-> PAUSE.  PAUSE -start-> RUN.
//     RUN (down mode) reaches 00:00.00 -> DONE. DONE ignores start_edge.
//     Any state -reset-> IDLE.
//   Event priority in one cycle: reset_edge > start_edge > lap_edge.
//   reset_edge:
//     - latches mode_down into the internal mode bit
//     - loads time = mode_down ? {preset_min,preset_sec,0} : 0
//     - clears prescaler, FIFO, lap_overflow and done
//   Countdown start from IDLE with time == 0: goes straight to DONE next cycle.
//   Prescaler:
//     - counts tick_1ms only while state == RUN at the start of the cycle
//     - a tick coinciding with start_edge is not counted
//     - on terminal count (TICKS_PER_CS-1) it wraps and steps time by one cs
//     - the new time is visible the cycle after that tick
//     - value is held across PAUSE
//   Up step: cs 99->0 carries to sec; sec 59->0 carries to min;
//     MAX_MINUTES:59.99 -> 00:00.00; keeps running, no flag.
//   Down step: borrows mirror up step. Reaching 00:00.00 sets done=1, running=0,
//     state DONE in the same update.
//   Lap push: lap_edge in RUN or PAUSE writes the time registered at that cycle
//     (pre-increment). Ignored in IDLE and DONE.
//   FIFO is show-ahead: lap_rd_data = head. lap_rd_en advances the read pointer;
//     the new head is valid next cycle.
//   Push and pop in the same cycle (non-empty): both happen, lap_count unchanged.
//   Push when full without a same-cycle pop: see CONFIGURATION.
//   Pointers wrap modulo LAP_DEPTH. lap_full = (lap_count == LAP_DEPTH).
// CONFIGURATION
//   LAP_OVERWRITE_EN defined:
//     - push when full writes the new entry at the head position and advances both
//       pointers, dropping the oldest entry
//     - lap_count stays LAP_DEPTH; lap_overflow <= 1
//   LAP_OVERWRITE_EN undefined:
//     - push when full is discarded; FIFO unchanged; lap_overflow <= 1
// TESTING
//   Up-count: reset, start, 1000 tick_1ms -> 00:01.00, running=1; start -> PAUSE,
//     further ticks leave 00:01.00.
//   Wrap: MAX_MINUTES=1, run to 01:59.99, one more cs -> 00:00.00, running stays 1.
//   Countdown: mode_down=1, preset 00:02, reset, start, 2000 ticks -> 00:00.00,
//     done=1, running=0; start_edge ignored.
//   Laps: laps at 00:00.50 and 00:01.20 -> lap_count=2; pop -> head 00:00.50,
//     then 00:01.20, then lap_empty=1.
//   Full FIFO (DEPTH=8), 9th lap:
//     - undefined macro: head still lap1, lap_overflow=1
//     - LAP_OVERWRITE_EN: head lap2, tail lap9, lap_count=8
//   Same cycle reset_edge + start_edge + lap_edge in RUN -> IDLE, time 0,
//     FIFO empty, lap_overflow=0; mid-run rst_n low -> all reset values immediately.

Source files
------------

// File: rtl/stopwatch_lap_core.sv
// Stopwatch timekeeping core: up/down count driven by the 1 ms tick, with a show-ahead lap FIFO.
// Optional feature: define LAP_OVERWRITE_EN so that a lap pushed into a full FIFO replaces the oldest entry.
module stopwatch_lap_core #(
  parameter int TICKS_PER_CS = 10,
  parameter int MAX_MINUTES  = 59,
  parameter int MIN_W        = 6,
  parameter int LAP_DEPTH    = 8,
  parameter int LAP_AW       = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_1ms,
  input  logic               start_edge,
  input  logic               reset_edge,
  input  logic               lap_edge,
  input  logic               mode_down,
  input  logic [MIN_W-1:0]   preset_min,
  input  logic [5:0]         preset_sec,
  output logic               running,
  output logic               done,
  output logic [MIN_W-1:0]   minutes,
  output logic [5:0]         seconds,
  output logic [6:0]         centiseconds,
  input  logic               lap_rd_en,
  output logic [MIN_W+12:0]  lap_rd_data,
  output logic [LAP_AW:0]    lap_count,
  output logic               lap_empty,
  output logic               lap_full,
  output logic               lap_overflow,
  output logic [1:0]         state_dbg
);

  localparam int EW = MIN_W + 13;
  localparam int PW = (TICKS_PER_CS > 1) ? $clog2(TICKS_PER_CS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state, state_n;
  logic              mode_q;
  logic [PW-1:0]     presc;
  logic [EW-1:0]     mem [LAP_DEPTH];
  logic [LAP_AW-1:0] wr_ptr, rd_ptr;

  logic              presc_en, cs_step, time_zero, step_zero;
  logic [MIN_W-1:0]  min_nx;
  logic [5:0]        sec_nx;
  logic [6:0]        cs_nx;
  logic              lap_push, lap_pop, mem_we, rd_adv;

  assign state_dbg   = state;
  assign lap_rd_data = mem[rd_ptr];
  assign lap_empty   = (lap_count == '0);
  assign lap_full    = (lap_count == (LAP_AW+1)'(LAP_DEPTH));
  assign time_zero   = (minutes == '0) && (seconds == '0) && (centiseconds == '0);
  assign cs_step     = presc_en && (presc == PW'(TICKS_PER_CS - 1));
  assign step_zero   = (min_nx == '0) && (sec_nx == '0) && (cs_nx == '0);

  // Time value one centisecond later (up) or earlier (down).
  always_comb begin
    min_nx = minutes;
    sec_nx = seconds;
    cs_nx  = centiseconds;
    if (!mode_q) begin
      if (centiseconds == 7'd99) begin
        cs_nx = '0;
        if (seconds == 6'd59) begin
          sec_nx = '0;
          min_nx = (minutes == MIN_W'(MAX_MINUTES)) ? '0 : minutes + MIN_W'(1);
        end else begin
          sec_nx = seconds + 6'd1;
        end
      end else begin
        cs_nx = centiseconds + 7'd1;
      end
    end else begin
      if (centiseconds == 7'd0) begin
        cs_nx = 7'd99;
        if (seconds == 6'd0) begin
          sec_nx = 6'd59;
          min_nx = minutes - MIN_W'(1);
        end else begin
          sec_nx = seconds - 6'd1;
        end
      end else begin
        cs_nx = centiseconds - 7'd1;
      end
    end
  end

  // Next state; reset_edge beats start_edge beats lap_edge and tick.
  always_comb begin
    state_n  = state;
    presc_en = 1'b0;
    lap_push = 1'b0;
    if (reset_edge) begin
      state_n = ST_IDLE;
    end else if (start_edge) begin
      case (state)
        ST_IDLE:  state_n = (mode_q && time_zero) ? ST_DONE : ST_RUN;
        ST_RUN:   state_n = ST_PAUSE;
        ST_PAUSE: state_n = ST_RUN;
        default:  state_n = state;
      endcase
    end else begin
      presc_en = (state == ST_RUN) && tick_1ms;
      lap_push = lap_edge && ((state == ST_RUN) || (state == ST_PAUSE));
      if (cs_step && mode_q && step_zero) state_n = ST_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      running <= (state_n == ST_RUN);
      done    <= (state_n == ST_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= 1'b0;
      presc        <= '0;
      minutes      <= '0;
      seconds      <= '0;
      centiseconds <= '0;
    end else if (reset_edge) begin
      mode_q       <= mode_down;
      presc        <= '0;
      minutes      <= mode_down ? preset_min : '0;
      seconds      <= mode_down ? preset_sec : '0;
      centiseconds <= '0;
    end else if (cs_step) begin
      presc        <= '0;
      minutes      <= min_nx;
      seconds      <= sec_nx;
      centiseconds <= cs_nx;
    end else if (presc_en) begin
      presc <= presc + PW'(1);
    end
  end

  // A full-FIFO overwrite is a push plus a forced pop of the oldest entry.
  assign lap_pop = lap_rd_en && !lap_empty && !reset_edge;
`ifdef LAP_OVERWRITE_EN
  assign mem_we = lap_push;
  assign rd_adv = lap_pop || (lap_push && lap_full);
`else
  assign mem_we = lap_push && (!lap_full || lap_pop);
  assign rd_adv = lap_pop;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      lap_count    <= '0;
      lap_overflow <= 1'b0;
    end else if (reset_edge) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      lap_count    <= '0;
      lap_overflow <= 1'b0;
    end else begin
      if (mem_we) wr_ptr <= wr_ptr + LAP_AW'(1);
      if (rd_adv) rd_ptr <= rd_ptr + LAP_AW'(1);
      if (lap_push && lap_full && !lap_pop) lap_overflow <= 1'b1;
      if (mem_we && !rd_adv)      lap_count <= lap_count + (LAP_AW+1)'(1);
      else if (!mem_we && rd_adv) lap_count <= lap_count - (LAP_AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr] <= {minutes, seconds, centiseconds};
  end

endmodule

// File: tb/tb_stopwatch_lap_core.sv
// Directed bench for stopwatch_lap_core: a default instance plus a fast-tick instance with MAX_MINUTES=1 for the wrap case.
module tb_stopwatch_lap_core;

  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // default instance
  logic        tick, start_e, reset_e, lap_e, mode_down, rd_en;
  logic [5:0]  preset_min, preset_sec;
  logic        running, done, lap_empty, lap_full, lap_overflow;
  logic [5:0]  minutes, seconds;
  logic [6:0]  centiseconds;
  logic [18:0] lap_rd_data;
  logic [3:0]  lap_count;
  logic [1:0]  state_dbg;

  stopwatch_lap_core dut (
    .clk(clk), .rst_n(rst_n), .tick_1ms(tick), .start_edge(start_e), .reset_edge(reset_e),
    .lap_edge(lap_e), .mode_down(mode_down), .preset_min(preset_min), .preset_sec(preset_sec),
    .running(running), .done(done), .minutes(minutes), .seconds(seconds),
    .centiseconds(centiseconds), .lap_rd_en(rd_en), .lap_rd_data(lap_rd_data),
    .lap_count(lap_count), .lap_empty(lap_empty), .lap_full(lap_full),
    .lap_overflow(lap_overflow), .state_dbg(state_dbg)
  );

  // wrap instance: one tick per centisecond, one-minute range
  logic        w_tick, w_start, w_reset;
  logic        w_running, w_done, w_empty, w_full, w_ovf;
  logic [5:0]  w_min, w_sec;
  logic [6:0]  w_cs;
  logic [18:0] w_rd_data;
  logic [3:0]  w_count;
  logic [1:0]  w_state;

  stopwatch_lap_core #(.TICKS_PER_CS(1), .MAX_MINUTES(1)) dut_w (
    .clk(clk), .rst_n(rst_n), .tick_1ms(w_tick), .start_edge(w_start), .reset_edge(w_reset),
    .lap_edge(1'b0), .mode_down(1'b0), .preset_min(6'd0), .preset_sec(6'd0),
    .running(w_running), .done(w_done), .minutes(w_min), .seconds(w_sec),
    .centiseconds(w_cs), .lap_rd_en(1'b0), .lap_rd_data(w_rd_data),
    .lap_count(w_count), .lap_empty(w_empty), .lap_full(w_full),
    .lap_overflow(w_ovf), .state_dbg(w_state)
  );

  // scoreboard
  logic [18:0] exp_q[$];
  int passes = 0;
  int total  = 0;

  function automatic logic [31:0] tv(input int m, input int s, input int c);
    return 32'({6'(m), 6'(s), 7'(c)});
  endfunction

  function automatic logic [31:0] now_t();
    return 32'({minutes, seconds, centiseconds});
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) cyc();
    tick = 1'b0;
  endtask

  task automatic pulse_start();
    start_e = 1'b1; cyc(); start_e = 1'b0;
  endtask

  task automatic pulse_reset();
    reset_e = 1'b1; cyc(); reset_e = 1'b0;
  endtask

  task automatic pulse_lap();
    lap_e = 1'b1; cyc(); lap_e = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1; cyc(); rd_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    {tick, start_e, reset_e, lap_e, mode_down, rd_en} = '0;
    preset_min = '0; preset_sec = '0;
    {w_tick, w_start, w_reset} = '0;
    #3;
    check("rst_running", 32'(running), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_time", now_t(), tv(0, 0, 0));
    check("rst_count", 32'(lap_count), 32'd0);
    check("rst_empty", 32'(lap_empty), 32'd1);
    check("rst_full_ovf", 32'({lap_full, lap_overflow}), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();

    // lap ignored in IDLE
    pulse_lap();
    check("idle_lap_ignored", 32'(lap_count), 32'd0);

    // up-count
    pulse_reset();
    pulse_start();
    check("up_state_run", 32'(state_dbg), 32'(S_RUN));
    ticks(1000);
    check("up_1s", now_t(), tv(0, 1, 0));
    check("up_running", 32'(running), 32'd1);
    pulse_start();
    check("pause_running", 32'(running), 32'd0);
    ticks(50);
    check("pause_hold", now_t(), tv(0, 1, 0));
    pulse_lap();
    check("pause_lap", 32'(lap_rd_data), tv(0, 1, 0));

    // prescaler held over pause; ticks on start_edge cycles not counted
    pulse_start();
    ticks(5);
    tick = 1'b1; pulse_start(); tick = 1'b0;
    ticks(20);
    tick = 1'b1; pulse_start(); tick = 1'b0;
    ticks(4);
    check("presc_hold_pre", now_t(), tv(0, 1, 0));
    ticks(1);
    check("presc_hold_step", now_t(), tv(0, 1, 1));

    // two laps
    pulse_reset();
    check("reset_clears_fifo", 32'(lap_empty), 32'd1);
    pulse_start();
    ticks(500);
    pulse_lap();
    ticks(700);
    pulse_lap();
    check("laps_count", 32'(lap_count), 32'd2);
    check("laps_head1", 32'(lap_rd_data), tv(0, 0, 50));
    pop();
    check("laps_head2", 32'(lap_rd_data), tv(0, 1, 20));
    pop();
    check("laps_empty", 32'(lap_empty), 32'd1);
    pop();
    check("pop_empty_ignored", 32'(lap_count), 32'd0);

    // full FIFO and ninth lap
    pulse_reset();
    pulse_start();
    for (int i = 1; i <= 9; i++) begin
      ticks(10);
      pulse_lap();
`ifdef LAP_OVERWRITE_EN
      if (i >= 2) exp_q.push_back(19'(tv(0, 0, i)));
`else
      if (i <= 8) exp_q.push_back(19'(tv(0, 0, i)));
`endif
    end
    check("full_count", 32'(lap_count), 32'd8);
    check("full_flag", 32'(lap_full), 32'd1);
    check("full_overflow", 32'(lap_overflow), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_%0d", i), 32'(lap_rd_data), 32'(exp_q.pop_front()));
      pop();
    end
    check("drain_empty", 32'(lap_empty), 32'd1);
    check("overflow_sticky", 32'(lap_overflow), 32'd1);

    // simultaneous push and pop
    ticks(10);
    pulse_lap();
    check("pp_head0", 32'(lap_rd_data), tv(0, 0, 10));
    ticks(10);
    lap_e = 1'b1; rd_en = 1'b1; cyc(); lap_e = 1'b0; rd_en = 1'b0;
    check("pp_count", 32'(lap_count), 32'd1);
    check("pp_head1", 32'(lap_rd_data), tv(0, 0, 11));

    // reset + start + lap together in RUN
    ticks(3);
    reset_e = 1'b1; start_e = 1'b1; lap_e = 1'b1; cyc();
    reset_e = 1'b0; start_e = 1'b0; lap_e = 1'b0;
    check("all3_state", 32'(state_dbg), 32'(S_IDLE));
    check("all3_time", now_t(), tv(0, 0, 0));
    check("all3_fifo", 32'({lap_empty, lap_overflow}), 32'b10);

    // countdown
    mode_down = 1'b1; preset_min = 6'd0; preset_sec = 6'd2;
    pulse_reset();
    check("cd_preset", now_t(), tv(0, 2, 0));
    pulse_start();
    ticks(1999);
    check("cd_last_cs", now_t(), tv(0, 0, 1));
    ticks(1);
    check("cd_zero", now_t(), tv(0, 0, 0));
    check("cd_done_run", 32'({done, running}), 32'b10);
    check("cd_state", 32'(state_dbg), 32'(S_DONE));
    pulse_start();
    ticks(20);
    check("cd_start_ignored", 32'({state_dbg, done}), 32'({S_DONE, 1'b1}));

    // countdown started at zero
    preset_sec = 6'd0;
    pulse_reset();
    check("cd0_cleared", 32'(done), 32'd0);
    pulse_start();
    check("cd0_done", 32'({state_dbg, done}), 32'({S_DONE, 1'b1}));

    // borrow across a minute
    preset_min = 6'd1;
    pulse_reset();
    pulse_start();
    ticks(10);
    check("cd_borrow", now_t(), tv(0, 59, 99));

    // asynchronous reset mid-run
    ticks(7);
    rst_n = 1'b0;
    #1;
    check("async_state", 32'({state_dbg, running, done}), 32'd0);
    check("async_time", now_t(), tv(0, 0, 0));
    check("async_fifo", 32'({lap_empty, lap_count}), 32'b10000);
    @(negedge clk);
    rst_n = 1'b1;
    mode_down = 1'b0;
    cyc();

    // wrap at MAX_MINUTES:59.99 on the fast instance
    w_reset = 1'b1; cyc(); w_reset = 1'b0;
    w_start = 1'b1; cyc(); w_start = 1'b0;
    w_tick = 1'b1;
    repeat (11999) cyc();
    check("wrap_max", 32'({w_min, w_sec, w_cs}), tv(1, 59, 99));
    cyc();
    w_tick = 1'b0;
    check("wrap_zero", 32'({w_min, w_sec, w_cs}), tv(0, 0, 0));
    check("wrap_running", 32'({w_running, w_done}), 32'b10);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
